// File: rtl/chess_key_conditioner.sv
// chess_key_conditioner
//   Turns the four raw, active-low chess-board push-buttons into clean,
//   single-cycle, active-low move commands for the layout-matrix stage.
//   Per key: 2-flop synchroniser -> debouncer -> RELEASED/HELD(/REPEATING)
//   FSM raising press requests. A fixed-priority arbiter (Left > Right > Up >
//   Down) lets one request through per cycle. Every pulse is followed by at
//   least one all-high cycle.
//
//   Optional feature macro: CHESS_KEY_AUTOREPEAT_EN
//     defined   : a held key re-issues its command after REPEAT_DELAY cycles,
//                 then every REPEAT_PERIOD cycles.
//     undefined : exactly one command per debounced press; the repeat
//                 counters and the REPEATING state are not built.
//
// Ports
//   clock     in   system clock, rising edge
//   resetApp  in   synchronous active-high reset
//   RawKeys   in   [3] Left, [2] Right, [1] Up, [0] Down; asynchronous, 0 = pressed
//   KeyLeft   out  active-low one-cycle command
//   KeyRight  out  active-low one-cycle command
//   KeyUp     out  active-low one-cycle command
//   KeyDown   out  active-low one-cycle command
//   HeldMask  out  debounced held level, 1 = held, same bit mapping as RawKeys
module chess_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned CNT_WIDTH       = 25
) (
  input  logic       clock,
  input  logic       resetApp,
  input  logic [3:0] RawKeys,
  output logic       KeyLeft,
  output logic       KeyRight,
  output logic       KeyUp,
  output logic       KeyDown,
  output logic [3:0] HeldMask
);

  localparam int unsigned NKEYS = 4;
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam longint unsigned CNT_LIMIT = 64'(1) << CNT_WIDTH;

  // Reject configurations whose terminal counts cannot be represented.
  if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= CNT_LIMIT ||
      64'(REPEAT_DELAY) >= CNT_LIMIT || 64'(REPEAT_PERIOD) >= CNT_LIMIT) begin : g_bad_cfg
    $error("chess_key_conditioner: counter parameters out of range for CNT_WIDTH");
  end

`ifdef CHESS_KEY_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] RPT_DELAY_V  = CNT_WIDTH'(REPEAT_DELAY);
  localparam logic [CNT_WIDTH-1:0] RPT_PERIOD_V = CNT_WIDTH'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_HELD      = 2'd1,
    ST_REPEATING = 2'd2
  } state_e;
`else
  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_HELD     = 1'b1
  } state_e;
`endif

  logic [NKEYS-1:0]     sync1_q, sync2_q;
  logic [NKEYS-1:0]     stable_q, stable_d;
  logic [CNT_WIDTH-1:0] db_cnt_q [NKEYS];
  logic [CNT_WIDTH-1:0] db_cnt_d [NKEYS];
  state_e               state_q  [NKEYS];
  state_e               state_d  [NKEYS];
  logic [NKEYS-1:0]     req_c;
  logic [NKEYS-1:0]     win_c;
  logic [NKEYS-1:0]     key_n_q, key_n_d;
  logic [NKEYS-1:0]     held_q;
`ifdef CHESS_KEY_AUTOREPEAT_EN
  logic [CNT_WIDTH-1:0] rpt_q [NKEYS];
  logic [CNT_WIDTH-1:0] rpt_d [NKEYS];
`endif

  // State registers.
  always_ff @(posedge clock) begin
    if (resetApp) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      key_n_q  <= '1;
      held_q   <= '0;
      for (int k = 0; k < NKEYS; k++) begin
        db_cnt_q[k] <= '0;
        state_q[k]  <= ST_RELEASED;
`ifdef CHESS_KEY_AUTOREPEAT_EN
        rpt_q[k]    <= '0;
`endif
      end
    end else begin
      sync1_q  <= RawKeys;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      key_n_q  <= key_n_d;
      held_q   <= ~stable_q;
      for (int k = 0; k < NKEYS; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
        state_q[k]  <= state_d[k];
`ifdef CHESS_KEY_AUTOREPEAT_EN
        rpt_q[k]    <= rpt_d[k];
`endif
      end
    end
  end

  // Debouncer: count consecutive disagreeing samples; flip on the last one.
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < NKEYS; k++) begin
      db_cnt_d[k] = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          stable_d[k] = ~stable_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + CNT_ONE;
        end
      end
    end
  end

  // Per-key press FSM; state advances whether or not its request wins.
  always_comb begin
    req_c = '0;
    for (int k = 0; k < NKEYS; k++) begin
      state_d[k] = state_q[k];
`ifdef CHESS_KEY_AUTOREPEAT_EN
      rpt_d[k]   = rpt_q[k];
`endif
      case (state_q[k])
        ST_RELEASED: begin
`ifdef CHESS_KEY_AUTOREPEAT_EN
          rpt_d[k] = '0;
`endif
          if (!stable_q[k]) begin
            state_d[k] = ST_HELD;
            req_c[k]   = 1'b1;
`ifdef CHESS_KEY_AUTOREPEAT_EN
            rpt_d[k]   = RPT_DELAY_V;
`endif
          end
        end
`ifdef CHESS_KEY_AUTOREPEAT_EN
        // Down-counter: expiry is the cycle it holds 1, so the next pulse
        // lands exactly DELAY/PERIOD edges after the previous one.
        ST_HELD, ST_REPEATING: begin
          if (stable_q[k]) begin
            state_d[k] = ST_RELEASED;
            rpt_d[k]   = '0;
          end else if (rpt_q[k] == CNT_ONE) begin
            state_d[k] = ST_REPEATING;
            req_c[k]   = 1'b1;
            rpt_d[k]   = RPT_PERIOD_V;
          end else if (rpt_q[k] != '0) begin
            rpt_d[k]   = rpt_q[k] - CNT_ONE;
          end
        end
`else
        ST_HELD: begin
          if (stable_q[k]) begin
            state_d[k] = ST_RELEASED;
          end
        end
`endif
        default: state_d[k] = ST_RELEASED;
      endcase
    end
  end

  // Fixed-priority arbiter with a mandatory all-high cycle after each pulse.
  always_comb begin
    win_c   = '0;
    key_n_d = '1;
    if (req_c[3])      win_c = 4'b1000;
    else if (req_c[2]) win_c = 4'b0100;
    else if (req_c[1]) win_c = 4'b0010;
    else if (req_c[0]) win_c = 4'b0001;
    if (key_n_q == '1) begin
      key_n_d = ~win_c;
    end
  end

  assign KeyLeft  = key_n_q[3];
  assign KeyRight = key_n_q[2];
  assign KeyUp    = key_n_q[1];
  assign KeyDown  = key_n_q[0];
  assign HeldMask = held_q;

endmodule

// File: tb/tb_chess_key_conditioner.sv
// Directed self-checking bench for chess_key_conditioner with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Inputs change 1 time unit after a rising edge ("edge 0"); outputs are
// sampled 1 time unit after each subsequent edge n.
module tb_chess_key_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;
  localparam int unsigned CW = 25;

  logic       clock = 1'b0;
  logic       resetApp;
  logic [3:0] RawKeys;
  logic       KeyLeft, KeyRight, KeyUp, KeyDown;
  logic [3:0] HeldMask;
  logic [3:0] keys;

  int errors = 0;
  int checks = 0;

  assign keys = {KeyLeft, KeyRight, KeyUp, KeyDown};

  chess_key_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_WIDTH      (CW)
  ) dut (
    .clock   (clock),
    .resetApp(resetApp),
    .RawKeys (RawKeys),
    .KeyLeft (KeyLeft),
    .KeyRight(KeyRight),
    .KeyUp   (KeyUp),
    .KeyDown (KeyDown),
    .HeldMask(HeldMask)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetApp = 1'b1;
    RawKeys  = 4'hF;
    step();
    step();
    checks++;
    if (keys !== 4'hF) begin
      errors++;
      $display("FAIL reset_keys got=%b exp=%b", keys, 4'hF);
    end
    checks++;
    if (HeldMask !== 4'h0) begin
      errors++;
      $display("FAIL reset_held got=%b exp=%b", HeldMask, 4'h0);
    end
    resetApp = 1'b0;
  endtask

  task automatic test_idle();
    RawKeys = 4'hF;
    for (int e = 1; e <= 50; e++) begin
      step();
      checks++;
      if (keys !== 4'hF || HeldMask !== 4'h0) begin
        errors++;
        $display("FAIL idle e=%0d keys=%b held=%b exp keys=1111 held=0000", e, keys, HeldMask);
      end
    end
  endtask

  // Release everything and let the debouncers return to idle.
  task automatic settle();
    RawKeys = 4'hF;
    for (int e = 1; e <= 12; e++) step();
    checks++;
    if (keys !== 4'hF || HeldMask !== 4'h0) begin
      errors++;
      $display("FAIL settle keys=%b held=%b exp keys=1111 held=0000", keys, HeldMask);
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_keys, exp_held;
    RawKeys = 4'b0111;
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_keys = (e == 7) ? 4'b0111 : 4'hF;
      exp_held = (e >= 7) ? 4'b1000 : 4'h0;
      checks++;
      if (keys !== exp_keys || HeldMask !== exp_held) begin
        errors++;
        $display("FAIL press_left e=%0d keys=%b held=%b exp keys=%b held=%b",
                 e, keys, HeldMask, exp_keys, exp_held);
      end
    end
    RawKeys = 4'hF;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_held = (e >= 7) ? 4'h0 : 4'b1000;
      checks++;
      if (keys !== 4'hF || HeldMask !== exp_held) begin
        errors++;
        $display("FAIL release_left e=%0d keys=%b held=%b exp keys=1111 held=%b",
                 e, keys, HeldMask, exp_held);
      end
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 30; c++) begin
      RawKeys = 4'hF;
      if (c < 20 && ((c / 2) % 2) == 0) RawKeys[1] = 1'b0;
      step();
      checks++;
      if (keys !== 4'hF || HeldMask !== 4'h0) begin
        errors++;
        $display("FAIL bounce_up c=%0d keys=%b held=%b exp keys=1111 held=0000", c, keys, HeldMask);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_keys, exp_held;
    RawKeys = 4'b1010;
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_keys = (e == 7) ? 4'b1011 : 4'hF;
      exp_held = (e >= 7) ? 4'b0101 : 4'h0;
      checks++;
      if (keys !== exp_keys || HeldMask !== exp_held) begin
        errors++;
        $display("FAIL simul_right_down e=%0d keys=%b held=%b exp keys=%b held=%b",
                 e, keys, HeldMask, exp_keys, exp_held);
      end
    end
  endtask

  // Left at edge 0; Right one edge later (lands in the gap cycle, dropped);
  // Down two edges later (lands after the gap, delivered).
  task automatic test_back_to_back();
    logic [3:0] exp_keys, exp_held;
    RawKeys = 4'b0111;
    for (int e = 1; e <= 14; e++) begin
      step();
      exp_keys = (e == 7) ? 4'b0111 : (e == 9) ? 4'b1110 : 4'hF;
      exp_held = (e >= 9) ? 4'b1101 : (e == 8) ? 4'b1100 : (e == 7) ? 4'b1000 : 4'h0;
      checks++;
      if (keys !== exp_keys || HeldMask !== exp_held) begin
        errors++;
        $display("FAIL back_to_back e=%0d keys=%b held=%b exp keys=%b held=%b",
                 e, keys, HeldMask, exp_keys, exp_held);
      end
      if (e == 1) RawKeys[2] = 1'b0;
      if (e == 2) RawKeys[0] = 1'b0;
    end
  endtask

  task automatic test_auto_repeat();
    logic [3:0] exp_keys, exp_held;
    bit         exp_pulse;
    RawKeys = 4'b1101;
    for (int e = 1; e <= 72; e++) begin
      step();
`ifdef CHESS_KEY_AUTOREPEAT_EN
      exp_pulse = (e == 7) || (e == 27) || (e == 35) || (e == 43) || (e == 51) || (e == 59);
`else
      exp_pulse = (e == 7);
`endif
      exp_keys = exp_pulse ? 4'b1101 : 4'hF;
      exp_held = (e >= 7 && e < 67) ? 4'b0010 : 4'h0;
      checks++;
      if (keys !== exp_keys || HeldMask !== exp_held) begin
        errors++;
        $display("FAIL repeat_up e=%0d keys=%b held=%b exp keys=%b held=%b",
                 e, keys, HeldMask, exp_keys, exp_held);
      end
      if (e == 60) RawKeys[1] = 1'b1;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] exp_keys, exp_held;
    RawKeys = 4'b0111;
    for (int e = 1; e <= 9; e++) begin
      step();
      exp_keys = (e == 7) ? 4'b0111 : 4'hF;
      exp_held = (e >= 7) ? 4'b1000 : 4'h0;
      checks++;
      if (keys !== exp_keys || HeldMask !== exp_held) begin
        errors++;
        $display("FAIL midreset_pre e=%0d keys=%b held=%b exp keys=%b held=%b",
                 e, keys, HeldMask, exp_keys, exp_held);
      end
    end
    resetApp = 1'b1;
    step();
    resetApp = 1'b0;
    checks++;
    if (keys !== 4'hF || HeldMask !== 4'h0) begin
      errors++;
      $display("FAIL midreset_at e=10 keys=%b held=%b exp keys=1111 held=0000", keys, HeldMask);
    end
    for (int e = 11; e <= 20; e++) begin
      step();
      exp_keys = (e == 17) ? 4'b0111 : 4'hF;
      exp_held = (e >= 17) ? 4'b1000 : 4'h0;
      checks++;
      if (keys !== exp_keys || HeldMask !== exp_held) begin
        errors++;
        $display("FAIL midreset_post e=%0d keys=%b held=%b exp keys=%b held=%b",
                 e, keys, HeldMask, exp_keys, exp_held);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_clean_press();
    settle();
    test_bounce();
    settle();
    test_simultaneous();
    settle();
    test_back_to_back();
    settle();
    test_auto_repeat();
    settle();
    test_reset_mid_hold();
    settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
